// File: rtl/ex_case_lut.sv
// Purpose : writable DEPTH-entry lookup table with pipelined hit/miss lookups and an FSM-driven full-table dump.
// Latency : a lookup or dump index issued at posedge N produces o_dv at posedge N+2; one result per cycle.
// Backpr. : none downstream; o_rdy=0 during DUMP/DRAIN and in reset, and requests seen then are dropped.
// Ports   : sclk/rst (sync, active-high); i_we/i_re/i_dump + i_addr/i_data requests; o_rdy accept;
//           o_dv/o_data/o_idx/o_hit result stream; o_err out-of-range write pulse; o_hit_cnt lookup hit count.
module ex_case_lut #(
    parameter int               DATA_W      = 10,
    parameter int               ADDR_W      = 8,
    parameter int               OUT_W       = 8,
    parameter int               DEPTH       = 16,
    parameter logic [OUT_W-1:0] DEFAULT_VAL = '0,
    parameter int               CNT_W       = 16
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              i_we,
    input  logic              i_re,
    input  logic              i_dump,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_rdy,
    output logic              o_dv,
    output logic [OUT_W-1:0]  o_data,
    output logic [ADDR_W-1:0] o_idx,
    output logic              o_hit,
    output logic              o_err,
    output logic [CNT_W-1:0]  o_hit_cnt
);
    localparam int IDX_W = $clog2(DEPTH);
    // Largest value that fits in an entry, widened to the input data width.
    localparam logic [DATA_W-1:0] SAT_MAX = DATA_W'({OUT_W{1'b1}});

    typedef enum logic [1:0] {ST_IDLE, ST_DUMP, ST_DRAIN} state_t;

    typedef struct packed {
        logic              vld;
        logic              lkp;   // 1 = user lookup (counts hits), 0 = dump result
        logic              hit;
        logic [OUT_W-1:0]  dat;
        logic [ADDR_W-1:0] idx;
    } stage_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  dump_idx_q, dump_idx_d;
    logic              drain_q, drain_d;
    logic              rdy_en_q, rdy_en_d;
    stage_t            s1_q, s1_d, s2_q, s2_d;
    logic              dv_q, dv_d, hit_q, hit_d, err_q, err_d;
    logic [OUT_W-1:0]  data_q, data_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [DEPTH-1:0]  ent_vld_q, ent_vld_d;
    logic [OUT_W-1:0]  mem_q [DEPTH];

    logic              dump_go, we_acc, re_acc, dump_iss;
    logic              wr_in_range, wr_en, rd_in_range;
    logic [IDX_W-1:0]  wr_slot, rd_slot;
    logic [OUT_W-1:0]  wr_val;
    logic [ADDR_W-1:0] rd_addr;

    // FSM output decode: acceptance of requests and dump issue.
    // A dump request wins over a simultaneous write/lookup.
    always_comb begin
        o_rdy    = rdy_en_q && (state_q == ST_IDLE);
        dump_go  = o_rdy && i_dump;
        we_acc   = o_rdy && i_we && !i_dump;
        re_acc   = o_rdy && i_re && !i_dump;
        dump_iss = (state_q == ST_DUMP);
    end

    // FSM next state.
    always_comb begin
        state_d    = state_q;
        dump_idx_d = dump_idx_q;
        drain_d    = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (dump_go) begin
                    state_d    = ST_DUMP;
                    dump_idx_d = '0;
                end
            end
            ST_DUMP: begin
                dump_idx_d = dump_idx_q + 1'b1;
                if (dump_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_DRAIN;
                    drain_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                // Second drain cycle: the last index leaves s2 on this edge,
                // so reopening here keeps results strictly in order.
                if (drain_q && !s1_q.vld) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: write port, read capture into s1 (pre-write contents), pipeline and outputs.
    always_comb begin
        rdy_en_d    = 1'b1;
        wr_in_range = {1'b0, i_addr} < (ADDR_W + 1)'(DEPTH);
        wr_en       = we_acc && wr_in_range;
        wr_slot     = i_addr[IDX_W-1:0];
        wr_val      = (i_data > SAT_MAX) ? {OUT_W{1'b1}} : i_data[OUT_W-1:0];
        ent_vld_d   = ent_vld_q;
        if (wr_en) begin
            ent_vld_d[wr_slot] = 1'b1;
        end

        rd_addr     = dump_iss ? ADDR_W'(dump_idx_q) : i_addr;
        rd_in_range = {1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH);
        rd_slot     = rd_addr[IDX_W-1:0];
        s1_d.vld    = re_acc || dump_iss;
        s1_d.lkp    = re_acc;
        s1_d.hit    = rd_in_range && ent_vld_q[rd_slot];
        s1_d.dat    = s1_d.hit ? mem_q[rd_slot] : DEFAULT_VAL;
        s1_d.idx    = rd_addr;
        s2_d        = s1_q;

        dv_d      = s2_q.vld;
        hit_d     = s2_q.vld && s2_q.hit;
        data_d    = s2_q.vld ? s2_q.dat : data_q;
        idx_d     = s2_q.vld ? s2_q.idx : idx_q;
        err_d     = we_acc && !wr_in_range;
        hit_cnt_d = hit_cnt_q;
        if (s2_q.vld && s2_q.lkp && s2_q.hit && (hit_cnt_q != {CNT_W{1'b1}})) begin
            hit_cnt_d = hit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dump_idx_q <= '0;
            drain_q    <= 1'b0;
            rdy_en_q   <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            dv_q       <= 1'b0;
            hit_q      <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= '0;
            idx_q      <= '0;
            hit_cnt_q  <= '0;
            ent_vld_q  <= '0;
        end else begin
            state_q    <= state_d;
            dump_idx_q <= dump_idx_d;
            drain_q    <= drain_d;
            rdy_en_q   <= rdy_en_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            dv_q       <= dv_d;
            hit_q      <= hit_d;
            err_q      <= err_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            hit_cnt_q  <= hit_cnt_d;
            ent_vld_q  <= ent_vld_d;
        end
    end

    // Entry storage has no reset; the valid bits turn stale contents into misses.
    always_ff @(posedge sclk) begin
        if (wr_en) begin
            mem_q[wr_slot] <= wr_val;
        end
    end

    assign o_dv      = dv_q;
    assign o_data    = data_q;
    assign o_idx     = idx_q;
    assign o_hit     = hit_q;
    assign o_err     = err_q;
    assign o_hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_ex_case_lut.sv
module tb_ex_case_lut;
    localparam int DATA_W  = 10;
    localparam int ADDR_W  = 8;
    localparam int OUT_W   = 8;
    localparam int DEPTH   = 16;
    localparam int DEF_VAL = 0;
    localparam int CNT_W   = 16;
    localparam int MAXV    = (1 << OUT_W) - 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int NCYC    = 4096;

    logic              sclk = 1'b0;
    logic              rst = 1'b1;
    logic              i_we = 1'b0, i_re = 1'b0, i_dump = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic [DATA_W-1:0] i_data = '0;
    logic              o_rdy, o_dv, o_hit, o_err;
    logic [OUT_W-1:0]  o_data;
    logic [ADDR_W-1:0] o_idx;
    logic [CNT_W-1:0]  o_hit_cnt;

    ex_case_lut #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W), .DEPTH(DEPTH),
                  .DEFAULT_VAL(OUT_W'(DEF_VAL)), .CNT_W(CNT_W)) dut (
        .sclk(sclk), .rst(rst), .i_we(i_we), .i_re(i_re), .i_dump(i_dump),
        .i_addr(i_addr), .i_data(i_data), .o_rdy(o_rdy), .o_dv(o_dv),
        .o_data(o_data), .o_idx(o_idx), .o_hit(o_hit), .o_err(o_err),
        .o_hit_cnt(o_hit_cnt));

    always #5 sclk = ~sclk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: table contents and a per-cycle schedule of expected results.
    int ref_mem [DEPTH];
    bit ref_vld [DEPTH];
    bit ev [NCYC];
    bit elk [NCYC];
    bit ehit [NCYC];
    int edat [NCYC];
    int eidx [NCYC];
    bit m_rdy = 0;
    int m_cnt = 0;
    int busy_until = 0;
    int hold_dat = 0;
    int hold_idx = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic sched(input int c, input bit lk, input int a);
        ev[c]   = 1;
        elk[c]  = lk;
        eidx[c] = a;
        ehit[c] = 0;
        if (a < DEPTH) ehit[c] = ref_vld[a];
        edat[c] = ehit[c] ? ref_mem[a] : DEF_VAL;
    endtask

    // One clock edge: predict from the current inputs, advance, compare every output.
    task automatic tick();
        int   e;
        bit   r, err_n, x_rdy, x_dv, x_hit, x_err;
        int   x_dat, x_idx;
        e = cyc + 1;
        r = rst;
        err_n = 0;
        if (r) begin
            for (int k = e; k < e + DEPTH + 4; k++) ev[k] = 0;
            for (int k = 0; k < DEPTH; k++) ref_vld[k] = 0;
            m_cnt = 0; busy_until = 0; hold_dat = 0; hold_idx = 0;
        end else if (m_rdy) begin
            if (i_dump) begin
                for (int k = 0; k < DEPTH; k++) sched(e + 3 + k, 0, k);
                busy_until = e + DEPTH + 2;
            end else begin
                if (i_re) sched(e + 2, 1, int'(i_addr));
                if (i_we) begin
                    if (int'(i_addr) < DEPTH) begin
                        ref_mem[int'(i_addr)] = (int'(i_data) > MAXV) ? MAXV : int'(i_data);
                        ref_vld[int'(i_addr)] = 1;
                    end else begin
                        err_n = 1;
                    end
                end
            end
        end
        @(posedge sclk);
        #1;
        cyc = e;
        if (r) begin
            x_rdy = 0; x_dv = 0; x_hit = 0; x_err = 0; x_dat = 0; x_idx = 0;
        end else begin
            x_rdy = (e >= busy_until);
            x_err = err_n;
            x_dv  = ev[e];
            x_hit = ev[e] && ehit[e];
            if (ev[e]) begin
                hold_dat = edat[e];
                hold_idx = eidx[e];
                if (elk[e] && ehit[e] && m_cnt < CNT_MAX) m_cnt++;
            end
            x_dat = hold_dat;
            x_idx = hold_idx;
        end
        m_rdy = x_rdy;
        chk("o_rdy", 32'(o_rdy), 32'(x_rdy));
        chk("o_dv", 32'(o_dv), 32'(x_dv));
        chk("o_hit", 32'(o_hit), 32'(x_hit));
        chk("o_err", 32'(o_err), 32'(x_err));
        chk("o_data", 32'(o_data), x_dat);
        chk("o_idx", 32'(o_idx), x_idx);
        chk("o_hit_cnt", 32'(o_hit_cnt), m_cnt);
    endtask

    task automatic drive(input bit we, input bit re, input bit dmp, input int a, input int d);
        i_we   = we;
        i_re   = re;
        i_dump = dmp;
        i_addr = ADDR_W'(a);
        i_data = DATA_W'(d);
    endtask

    initial begin
        int n_dv, n_rdy0;
        logic [DEPTH-1:0] hit_map;

        // Reset for 3 cycles, then release.
        drive(0, 0, 0, 0, 0);
        rst = 1;
        repeat (3) tick();
        chk("reset_rdy", 32'(o_rdy), 0);
        rst = 0;
        tick();
        chk("rdy_after_release", 32'(o_rdy), 1);

        // Write 0..3, then look them up back-to-back.
        for (int k = 0; k < 4; k++) begin drive(1, 0, 0, k, k); tick(); end
        for (int k = 0; k < 4; k++) begin drive(0, 1, 0, k, 0); tick(); end
        drive(0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("hit_cnt_4", 32'(o_hit_cnt), 4);

        // Saturating write, never-written miss, out-of-range write.
        drive(1, 0, 0, 5, 10'h3FF); tick();
        drive(0, 1, 0, 5, 0); tick();
        drive(0, 0, 0, 0, 0); tick(); tick();
        chk("sat_data", 32'(o_data), 32'hFF);
        chk("sat_hit", 32'(o_hit), 1);
        drive(0, 1, 0, 6, 0); tick();
        drive(0, 0, 0, 0, 0); tick(); tick();
        chk("miss_hit", 32'(o_hit), 0);
        chk("miss_data", 32'(o_data), DEF_VAL);
        drive(1, 0, 0, 20, 7); tick();
        chk("oor_err", 32'(o_err), 1);
        drive(0, 1, 0, 20, 0); tick();
        drive(0, 0, 0, 0, 0); tick(); tick();
        chk("oor_lookup_hit", 32'(o_hit), 0);
        chk("oor_lookup_idx", 32'(o_idx), 20);

        // Same-cycle write and read: read sees the old value, next read the new one.
        drive(1, 0, 0, 2, 8'h11); tick();
        drive(1, 1, 0, 2, 8'h22); tick();
        drive(0, 1, 0, 2, 0); tick();
        drive(0, 0, 0, 0, 0); tick();
        chk("rbw_old", 32'(o_data), 32'h11);
        tick();
        chk("rbw_new", 32'(o_data), 32'h22);
        tick();

        // Full dump with lookups attempted while busy.
        n_dv = 0; n_rdy0 = 0; hit_map = '0;
        drive(0, 0, 1, 0, 0); tick();
        if (!o_rdy) n_rdy0++;
        for (int k = 0; k < 19; k++) begin
            drive(0, (k < 6), 0, 1, 0);
            tick();
            if (o_dv) begin n_dv++; if (o_hit) hit_map[o_idx[3:0]] = 1'b1; end
            if (!o_rdy) n_rdy0++;
        end
        drive(0, 0, 0, 0, 0);
        chk("dump_dv_count", 32'(n_dv), DEPTH);
        chk("dump_rdy_low", 32'(n_rdy0), DEPTH + 2);
        chk("dump_hit_map", 32'(hit_map), 32'h002F);
        chk("dump_hit_cnt", 32'(o_hit_cnt), 7);

        // Reset in the middle of a dump.
        drive(0, 0, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        repeat (10) tick();
        chk("dump_idx7_dv", 32'(o_dv), 1);
        chk("dump_idx7", 32'(o_idx), 7);
        rst = 1; tick();
        chk("abort_dv", 32'(o_dv), 0);
        tick();
        rst = 0; tick(); tick();
        chk("abort_dv_after", 32'(o_dv), 0);
        drive(0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0); tick(); tick();
        chk("post_reset_dv", 32'(o_dv), 1);
        chk("post_reset_hit", 32'(o_hit), 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            drive($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 39) == 0),
                  $urandom_range(0, 23),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(256, 1023) : $urandom_range(0, 255));
            tick();
        end
        rst = 0;
        drive(0, 0, 0, 0, 0);
        repeat (24) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_case_lut.md
Name: ex_case_lut

Overview:
Parametrised successor to the fixed-width case decoder. It holds a writable DEPTH-entry lookup table that replaces the hard-coded case arms. Lookups are pipelined with a fixed latency and return hit/miss status. A dump mode streams the whole table out under FSM control. It sits between the address/data stimulus source and downstream consumers of the o_dv/o_data stream.

Parameters:
DATA_W, 10, input data width; must be >= OUT_W.
ADDR_W, 8, input address width.
OUT_W, 8, output/stored entry width.
DEPTH, 16, number of table entries; power of 2; IDX_W = log2(DEPTH) <= ADDR_W.
DEFAULT_VAL, 0, o_data value returned on a miss (OUT_W bits).
CNT_W, 16, hit counter width.

Ports:
sclk  in  1  clock; all logic on posedge.
rst  in  1  synchronous reset, active-high.
i_we  in  1  table write request.
i_re  in  1  lookup request.
i_dump  in  1  start a full-table dump (pulse).
i_addr  in  ADDR_W  entry address for write/lookup.
i_data  in  DATA_W  write data.
o_rdy  out  1  high = i_we/i_re/i_dump accepted this cycle.
o_dv  out  1  result valid, one cycle per result.
o_data  out  OUT_W  result value.
o_idx  out  ADDR_W  address belonging to o_data.
o_hit  out  1  qualifies o_dv: entry in range and written since reset.
o_err  out  1  one-cycle pulse: write to out-of-range address rejected.
o_hit_cnt  out  CNT_W  saturating count of lookup hits.

Behaviour:
- Reset (rst=1 at posedge): all entry valid bits cleared; FSM to IDLE; pipeline flushed.
  - Reset output values: o_dv=0, o_data=0, o_idx=0, o_hit=0, o_err=0, o_hit_cnt=0, o_rdy=0.
  - o_rdy rises the cycle after rst deasserts.
  - Table contents are don't-care after reset; valid bits make them misses.
  - Reset mid-lookup or mid-dump aborts it: no further o_dv.
- FSM states: IDLE (o_rdy=1), DUMP (o_rdy=0), DRAIN (o_rdy=0).
  - IDLE -> DUMP on i_dump while o_rdy=1.
  - DUMP -> DRAIN after issuing index DEPTH-1.
  - DRAIN -> IDLE after 2 cycles, once the pipeline is empty.
  - i_we/i_re/i_dump while o_rdy=0 are ignored, with no side effects.
- Write (IDLE, i_we=1):
  - If i_addr < DEPTH: entry[i_addr] is stored at the posedge and its valid bit is set.
  - Width rule: if i_data > 2^OUT_W-1, store all-ones (saturate); otherwise store i_data[OUT_W-1:0].
  - If i_addr >= DEPTH: no store; o_err=1 on the next cycle.
- Lookup (IDLE, i_re=1 at posedge N):
  - o_dv=1 at posedge N+2, with o_idx=i_addr.
  - Hit (in range and valid): o_hit=1, o_data=entry.
  - Miss: o_hit=0, o_data=DEFAULT_VAL.
  - Fully pipelined: one lookup per cycle, back-to-back, in order.
- Simultaneous i_we and i_re in the same cycle:
  - Both are accepted.
  - The lookup sees the pre-write contents (read-before-write).
  - A lookup in the following cycle sees the new value.
  - i_dump together with i_we/i_re: dump wins; the write and lookup are dropped.
- Dump: issues indices 0..DEPTH-1, one per cycle, through the same 2-cycle pipeline.
  - Each result: o_dv=1, o_idx=index, and o_hit/o_data follow the lookup rules.
  - Produces exactly DEPTH consecutive o_dv cycles.
  - Dump results do not increment o_hit_cnt.
- o_hit_cnt: increments by 1 on each lookup o_dv with o_hit=1; holds at 2^CNT_W-1.
- Outside valid cycles: o_dv=0, o_hit=0; o_data and o_idx are held at their last values.

Test Plan:
- Reset then idle: rst=1 for 3 cycles -> all outputs 0, o_rdy=0. Release -> o_rdy=1 the next cycle.
- Write addr 0..3 with data 0..3, then lookup 0..3 back-to-back -> o_dv for 4 consecutive cycles starting 2 cycles after the first i_re. o_data/o_idx = 0,1,2,3; o_hit=1; o_hit_cnt=4.
- Saturation and miss:
  - Write addr 5 data 10'h3FF, lookup 5 -> o_data=8'hFF, o_hit=1.
  - Lookup addr 6 (never written) -> o_data=DEFAULT_VAL=0, o_hit=0.
  - Write addr 20 -> o_err pulse, no store; lookup 20 -> o_hit=0.
- Same-cycle write+read: entry 2=8'h11, then i_we addr2 data 8'h22 together with i_re addr2 -> result 8'h11. A lookup of addr 2 the next cycle -> 8'h22.
- Dump after the writes above -> 16 consecutive o_dv, o_idx 0..15, o_hit=1 only at 0,1,2,3,5. o_rdy=0 for 18 cycles; i_re during the dump is ignored; o_hit_cnt unchanged.
- Reset during the dump at index 7 -> o_dv=0 from the next cycle; after release, a lookup of addr 0 returns o_hit=0.
